// File: rtl/decoder_seq_pkg.sv
// Shared state encoding, mode constants and sizing helper for decoder_seq.
package decoder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_HOLD = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    // The hold counter only ever holds HOLD_CYC-1, but keep at least one bit.
    function automatic int unsigned hold_cnt_w(input int unsigned hold_cyc);
        int unsigned w;
        w = $clog2(hold_cyc);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational index-to-one-hot converter; indices at or beyond NUM_OUT give zero.
module decoder_onehot #(
    parameter int unsigned IN_W    = 4,
    parameter int unsigned NUM_OUT = 16
) (
    input  logic                en,
    input  logic [IN_W-1:0]     idx,
    output logic [NUM_OUT-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (en && (idx == IN_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot select sequencer with HOLD and SCAN modes.
// Optional odd-parity request check enabled by DECODER_SEQ_PARITY_EN.
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int unsigned IN_W     = 4,
    parameter int unsigned NUM_OUT  = 16,
    parameter int unsigned HOLD_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic                ip_valid,
    output logic                ip_ready,
    input  logic [IN_W-1:0]     ip,
`ifdef DECODER_SEQ_PARITY_EN
    input  logic                ip_par,
`endif
    output logic [NUM_OUT-1:0]  op,
    output logic                op_valid,
    output logic                scan_done,
    output logic                err
);

    localparam int unsigned      CNT_W     = hold_cnt_w(HOLD_CYC);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [IN_W:0]    LIMIT     = (IN_W + 1)'(NUM_OUT);
    localparam logic [IN_W-1:0]  LAST_IDX  = IN_W'(NUM_OUT - 1);

    state_t            state_q, state_d;
    logic [IN_W-1:0]   idx_q, idx_d;
    logic [IN_W-1:0]   start_q, start_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              accept;
    logic              req_bad;
    logic [IN_W-1:0]   idx_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        accept  = ip_valid & ip_ready;
`ifdef DECODER_SEQ_PARITY_EN
        req_bad = ~(^{ip, ip_par}) | ({1'b0, ip} >= LIMIT);
`else
        req_bad = ({1'b0, ip} >= LIMIT);
`endif
        // Wrap at NUM_OUT, not at the natural 2**IN_W boundary.
        idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + IN_W'(1);

        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_bad) begin
                            err_d = 1'b1;
                        end else begin
                            idx_d   = ip;
                            start_d = ip;
                            state_d = (mode == MODE_SCAN) ? SCAN : HOLD;
                            if (mode == MODE_HOLD) begin
                                cnt_d = HOLD_LOAD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                SCAN: begin
                    if (idx_nxt == start_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    decoder_onehot #(
        .IN_W    (IN_W),
        .NUM_OUT (NUM_OUT)
    ) u_onehot (
        .en     (state_q != IDLE),
        .idx    (idx_q),
        .onehot (op)
    );

    always_comb begin
        ip_ready  = en & (state_q == IDLE);
        op_valid  = |op;
        err       = err_q;
        scan_done = done_q;
    end

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq (NUM_OUT=12, HOLD_CYC=3) with a queue-based reference model.
// Parity cases run only when DECODER_SEQ_PARITY_EN is defined.
module tb_decoder_seq;
    import decoder_seq_pkg::*;

    localparam int unsigned NO = 12;
    localparam int unsigned HC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          mode;
    logic          ip_valid;
    logic          ip_ready;
    logic [3:0]    ip;
`ifdef DECODER_SEQ_PARITY_EN
    logic          ip_par;
`endif
    logic [NO-1:0] op;
    logic          op_valid;
    logic          scan_done;
    logic          err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct packed {
        logic [NO-1:0] op;
        logic          last;
    } ent_t;

    ent_t q[$];
    logic m_err  = 1'b0;
    logic m_done = 1'b0;

    logic [NO-1:0] scan_exp [12] = '{12'h400, 12'h800, 12'h001, 12'h002, 12'h004, 12'h008,
                                     12'h010, 12'h020, 12'h040, 12'h080, 12'h100, 12'h200};

    decoder_seq #(
        .IN_W     (4),
        .NUM_OUT  (NO),
        .HOLD_CYC (HC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .ip_valid  (ip_valid),
        .ip_ready  (ip_ready),
        .ip        (ip),
`ifdef DECODER_SEQ_PARITY_EN
        .ip_par    (ip_par),
`endif
        .op        (op),
        .op_valid  (op_valid),
        .scan_done (scan_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NO-1:0] oh(input int unsigned i);
        logic [NO-1:0] w;
        w = '0;
        w[i] = 1'b1;
        return w;
    endfunction

    function automatic logic req_rejected();
        logic r;
        r = (int'(ip) >= int'(NO));
`ifdef DECODER_SEQ_PARITY_EN
        if ((^{ip, ip_par}) == 1'b0) r = 1'b1;
`endif
        return r;
    endfunction

    // Reference: an accepted request schedules its whole output sequence.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_err  <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_err  <= 1'b0;
            m_done <= 1'b0;
            if (!en) begin
                q.delete();
            end else if (q.size() != 0) begin
                if (q[0].last) m_done <= 1'b1;
                void'(q.pop_front());
            end else if (ip_valid) begin
                if (req_rejected()) begin
                    m_err <= 1'b1;
                end else if (mode == MODE_HOLD) begin
                    for (int k = 0; k < int'(HC); k++) q.push_back('{op: oh(ip), last: 1'b0});
                end else begin
                    for (int k = 0; k < int'(NO); k++)
                        q.push_back('{op: oh((int'(ip) + k) % NO), last: (k == int'(NO) - 1)});
                end
            end
        end
    end

    always @(posedge clk) begin
        logic [NO-1:0] e_op;
        #2;
        e_op = (q.size() != 0) ? q[0].op : '0;
        chk("m_op", op, e_op);
        chk("m_op_valid", op_valid, q.size() != 0);
        chk("m_ip_ready", ip_ready, en && (q.size() == 0));
        chk("m_err", err, m_err);
        chk("m_scan_done", scan_done, m_done);
        chk("onehot0", $onehot0(op), 1);
        chk("err_done_excl", err & scan_done, 0);
    end

    task automatic drive(input logic v, input logic m, input logic [3:0] i);
        ip_valid = v;
        mode     = m;
        ip       = i;
`ifdef DECODER_SEQ_PARITY_EN
        ip_par   = ~(^i);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        drive(1'b0, MODE_HOLD, 4'd0);
        #12;
        chk("rst_op", op, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_done", scan_done, 0);
        step();
        rst = 1'b0;
        #1;
        chk("rel_ready", ip_ready, 1);

        // HOLD, index 9, three cycles
        drive(1'b1, MODE_HOLD, 4'd9);
        step();
        drive(1'b0, MODE_HOLD, 4'd0);
        for (int k = 1; k <= 3; k++) begin
            chk("hold_op", op, 12'h200);
            chk("hold_ready", ip_ready, 0);
            step();
        end
        chk("hold_end_op", op, 0);
        chk("hold_end_ready", ip_ready, 1);

        // Request held valid across HOLD completion: re-accept one cycle late
        drive(1'b1, MODE_HOLD, 4'd2);
        repeat (9) step();
        drive(1'b0, MODE_HOLD, 4'd0);
        repeat (4) step();

        // SCAN from 10 wraps at 12
        drive(1'b1, MODE_SCAN, 4'd10);
        step();
        drive(1'b0, MODE_HOLD, 4'd0);
        for (int k = 0; k < 12; k++) begin
            chk("scan_op", op, scan_exp[k]);
            chk("scan_no_done", scan_done, 0);
            step();
        end
        chk("scan_end_op", op, 0);
        chk("scan_end_valid", op_valid, 0);
        chk("scan_done_pulse", scan_done, 1);
        chk("scan_done_ready", ip_ready, 1);
        step();
        chk("scan_done_clear", scan_done, 0);

        // Range boundaries
        drive(1'b1, MODE_HOLD, 4'd13);
        step();
        drive(1'b0, MODE_HOLD, 4'd0);
        chk("oor13_err", err, 1);
        chk("oor13_op", op, 0);
        chk("oor13_ready", ip_ready, 1);
        step();
        chk("oor13_err_clear", err, 0);
        drive(1'b1, MODE_SCAN, 4'd12);
        step();
        drive(1'b0, MODE_HOLD, 4'd0);
        chk("oor12_err", err, 1);
        step();
        drive(1'b1, MODE_SCAN, 4'd15);
        step();
        drive(1'b0, MODE_HOLD, 4'd0);
        chk("oor15_err", err, 1);
        step();
        drive(1'b1, MODE_HOLD, 4'd11);
        step();
        drive(1'b0, MODE_HOLD, 4'd0);
        chk("in11_op", op, 12'h800);
        chk("in11_err", err, 0);
        repeat (4) step();

        // Reset in the middle of a scan
        drive(1'b1, MODE_SCAN, 4'd5);
        step();
        drive(1'b0, MODE_HOLD, 4'd0);
        step();
        step();
        chk("pre_rst_op", op, 12'h080);
        rst = 1'b1;
        #1;
        chk("async_rst_op", op, 0);
        chk("async_rst_valid", op_valid, 0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ip_ready, 1);
        repeat (14) step();

        // Enable dropped during a scan
        drive(1'b1, MODE_SCAN, 4'd0);
        step();
        drive(1'b0, MODE_HOLD, 4'd0);
        step();
        chk("en_scan_op", op, 12'h002);
        en = 1'b0;
        #1;
        chk("en_low_ready", ip_ready, 0);
        drive(1'b1, MODE_HOLD, 4'd3);
        step();
        chk("en_abort_op", op, 0);
        chk("en_abort_done", scan_done, 0);
        chk("en_abort_ready", ip_ready, 0);
        step();
        chk("en_masked_op", op, 0);
        drive(1'b0, MODE_HOLD, 4'd0);
        en = 1'b1;
        #1;
        chk("en_back_ready", ip_ready, 1);
        repeat (3) step();

`ifdef DECODER_SEQ_PARITY_EN
        drive(1'b1, MODE_HOLD, 4'b0011);
        ip_par = 1'b0;
        step();
        drive(1'b0, MODE_HOLD, 4'd0);
        chk("par_bad_err", err, 1);
        chk("par_bad_op", op, 0);
        step();
        drive(1'b1, MODE_HOLD, 4'b0011);
        ip_par = 1'b1;
        step();
        drive(1'b0, MODE_HOLD, 4'd0);
        chk("par_ok_op", op, 12'h008);
        chk("par_ok_err", err, 0);
        repeat (4) step();
`endif

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, registered successor to the team's 4-to-16 enable decoder.
- Converts an accepted binary index into a registered one-hot select word, using a valid/ready handshake.
- Two modes:
  - HOLD: assert one output for a programmable number of cycles.
  - SCAN: walk the active bit once around all outputs, starting at the given index.
- Used as a chip-select / row-strobe sequencer behind address decode logic.

Parameters:
- IN_W, 4, index width in bits.
- NUM_OUT, 16, number of one-hot outputs. Must satisfy 2 <= NUM_OUT <= 2**IN_W.
- HOLD_CYC, 1, cycles op stays asserted in HOLD mode. Must be >= 1.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; low aborts any operation.
- mode  in  1  0 = HOLD, 1 = SCAN; sampled on accept.
- ip_valid  in  1  request valid.
- ip_ready  out  1  block can accept a request.
- ip  in  IN_W  binary index.
- op  out  NUM_OUT  registered one-hot select.
- op_valid  out  1  op carries an active select.
- scan_done  out  1  one-cycle pulse at the end of a scan.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (async assert, sync deassert use): state = IDLE, op = 0, op_valid = 0, scan_done = 0, err = 0, all counters = 0. ip_ready = 1 once reset is low.
- Reset asserted mid-operation clears all state immediately; nothing resumes.
- ip_ready = en & (state == IDLE). It is combinational.
- Accept occurs when ip_valid & ip_ready at a clock edge.
- State IDLE:
  - On accept with ip >= NUM_OUT: err = 1 for the next cycle, stay IDLE, op stays 0.
  - On accept with mode = 0: at the next edge, op = onehot(ip), op_valid = 1, hold counter = HOLD_CYC - 1, go to HOLD. Latency from accept edge to op is 1 cycle.
  - On accept with mode = 1: at the next edge, op = onehot(ip), op_valid = 1, start index = ip, go to SCAN.
- State HOLD:
  - While the hold counter != 0, decrement it and keep op.
  - When the counter == 0, at the next edge op = 0, op_valid = 0, go to IDLE.
  - op is therefore high for exactly HOLD_CYC cycles.
- State SCAN:
  - Each cycle the index advances by 1 and op is rotated to match.
  - Wrap rule: NUM_OUT - 1 goes to 0. This is modulo NUM_OUT, not modulo 2**IN_W.
  - When the next index equals the start index: op = 0, op_valid = 0, scan_done = 1 for one cycle, go to IDLE.
  - A scan therefore visits exactly NUM_OUT outputs, one per cycle.
- Enable:
  - en low in any state: at the next edge op = 0, op_valid = 0, go to IDLE. No scan_done pulse is produced.
  - en low also masks acceptance through ip_ready.
- Simultaneous events:
  - rst dominates en, and en dominates the state machine.
  - A request presented on the cycle HOLD or SCAN finishes is not accepted. ip_ready is still 0 that cycle, so the earliest re-accept is the following cycle.
- Output invariants:
  - op is all-zero or exactly one-hot, every cycle.
  - op_valid = |op.
  - err and scan_done never assert in the same cycle.

Optional Feature:
- Macro: DECODER_SEQ_PARITY_EN.
- Defined:
  - Adds input ip_par (1 bit), giving odd parity over {ip, ip_par}.
  - On accept with a parity mismatch: err pulses and the request is dropped. This is handled exactly like an out-of-range index.
  - The parity check takes precedence over the range check. The err pulse is identical in both cases.
- Undefined:
  - The ip_par port is absent.
  - Only out-of-range requests raise err.

Decomposition:
- Package decoder_seq_pkg holds:
  - the state enum, 2 bits: IDLE = 0, HOLD = 1, SCAN = 2;
  - the mode constants MODE_HOLD = 0 and MODE_SCAN = 1;
  - a function for the hold-counter width, $clog2(HOLD_CYC) with a minimum of 1.
- Sub-module decoder_onehot (parameters IN_W, NUM_OUT):
  - purely combinational index-to-one-hot conversion with an enable input;
  - output is 0 for out-of-range indices;
  - instantiated once, driven by the registered index.

Test Plan:
- Reset mid-SCAN (NUM_OUT = 16, start at 5, rst asserted on cycle 3) -> op = 0, op_valid = 0 within the same cycle; ip_ready = 1 after release.
- HOLD, HOLD_CYC = 3, ip = 4'd9, en = 1 -> op = 16'h0200 on cycles 1-3 after accept; op = 0 on cycle 4; ip_ready low on cycles 1-3.
- SCAN, NUM_OUT = 12, ip = 10 -> op sequence bit10, 11, 0, 1 … 9 (12 cycles), then op = 0 with scan_done = 1 for one cycle.
- Out-of-range index, NUM_OUT = 12, ip = 13 -> err = 1 for one cycle, op stays 0, state stays IDLE.
- en dropped on cycle 2 of a 16-step scan -> op = 0 on the next cycle, no scan_done, ip_ready stays 0 until en returns.
- With DECODER_SEQ_PARITY_EN, ip = 4'b0011 and ip_par = 0 (even, so mismatch) -> err pulse, no op. The same request with ip_par = 1 -> op = 16'h0008.
